// File: rtl/datamem_arbiter.sv
// Round-robin arbiter sharing a single-port byte-addressed data memory between
// the CPU LSU (requester 0) and the debug/loader port (requester 1).
module datamem_arbiter #(
    parameter int MEM_BYTES  = 512,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0]              req_we,
    input  logic [3:0]              req_size,
    input  logic [1:0]              req_unsigned,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]             req_wdata,
    output logic [1:0]              resp_valid,
    output logic [31:0]             resp_rdata,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [31:0]             mem_wdata,
    output logic [3:0]              mem_be,
    output logic                    mem_wen,
    input  logic [31:0]             mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    localparam logic [ADDR_WIDTH:0] MEM_LIM = (ADDR_WIDTH+1)'(MEM_BYTES);

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic                  gnt_q, gnt_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic                  err_q, err_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic                  mem_wen_q, mem_wen_d;

    // Fields of the requester that would be granted this cycle
    logic                  any_req, sel;
    logic                  s_we, s_uns;
    logic [1:0]            s_size, s_off;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [31:0]           s_wdata, s_lanes;
    logic [2:0]            s_bytes;
    logic [3:0]            s_mask;
    logic                  s_misal, s_err;
    logic [ADDR_WIDTH:0]   s_end;

    always_comb begin
        any_req = |req_valid;
        sel     = (&req_valid) ? ptr_q : req_valid[1];
        s_we    = sel ? req_we[1]       : req_we[0];
        s_uns   = sel ? req_unsigned[1] : req_unsigned[0];
        s_size  = sel ? req_size[3:2]   : req_size[1:0];
        s_addr  = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
        s_wdata = sel ? req_wdata[63:32] : req_wdata[31:0];
        s_off   = s_addr[1:0];
    end

    // Big-endian lanes: offset 0 lives in bits [31:24]
    always_comb begin
        s_bytes = 3'd1;
        s_mask  = 4'b1000 >> s_off;
        s_lanes = {4{s_wdata[7:0]}};
        s_misal = 1'b0;
        case (s_size)
            2'b00: ;
            2'b01: begin
                s_bytes = 3'd2;
                s_mask  = 4'b1100 >> s_off;
                s_lanes = {2{s_wdata[15:0]}};
                s_misal = s_addr[0];
            end
            2'b10: begin
                s_bytes = 3'd4;
                s_mask  = 4'b1111;
                s_lanes = s_wdata;
                s_misal = |s_addr[1:0];
            end
            default: s_misal = 1'b1;
        endcase
        // One extra bit so an access straddling the top of the address space cannot wrap
        s_end = {1'b0, s_addr} + (ADDR_WIDTH+1)'(s_bytes);
        s_err = s_misal | (s_end > MEM_LIM);
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = 4'b0000;
        mem_wen_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = ISSUE;
                    gnt_d       = sel;
                    ptr_d       = ~sel;
                    we_d        = s_we;
                    size_d      = s_size;
                    uns_d       = s_uns;
                    off_d       = s_off;
                    err_d       = s_err;
                    mem_addr_d  = {s_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_wdata_d = s_lanes;
                    mem_be_d    = s_err ? 4'b0000 : s_mask;
                    mem_wen_d   = s_we & ~s_err;
                end
            end
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'b0000;
            mem_wen_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_wen_q   <= mem_wen_d;
        end
    end

    // Ready is masked by reset so a held request never shows an acceptance during reset
    always_comb begin
        req_ready = 2'b00;
        if (rst_n && state_q == IDLE && any_req)
            req_ready = sel ? 2'b10 : 2'b01;
    end

    logic [31:0] rd_sh;

    always_comb begin
        resp_valid = 2'b00;
        resp_rdata = '0;
        resp_err   = 1'b0;
        rd_sh      = mem_rdata << {off_q, 3'b000};
        if (state_q == RESP) begin
            resp_valid = gnt_q ? 2'b10 : 2'b01;
            resp_err   = err_q;
            if (!we_q && !err_q) begin
                case (size_q)
                    2'b00:   resp_rdata = {{24{~uns_q & rd_sh[31]}}, rd_sh[31:24]};
                    2'b01:   resp_rdata = {{16{~uns_q & rd_sh[31]}}, rd_sh[31:16]};
                    default: resp_rdata = rd_sh;
                endcase
            end
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign mem_wen   = mem_wen_q;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Directed bench for datamem_arbiter with a 1-cycle registered-read memory model.
module tb_datamem_arbiter;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid, req_ready, req_we, req_unsigned, resp_valid;
    logic [3:0]    req_size, mem_be;
    logic [2*AW-1:0] req_addr;
    logic [63:0]   req_wdata;
    logic [31:0]   resp_rdata, mem_wdata, mem_rdata;
    logic          resp_err, mem_wen;
    logic [AW-1:0] mem_addr;

    int checks = 0;
    int errors = 0;
    int wen_cnt = 0;

    logic [31:0] mem [0:127] = '{default: 32'h0};

    logic [3:0]  c_be;
    logic        c_wen, c_err;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic [1:0]  c_rv, c_rdy;

    datamem_arbiter #(.MEM_BYTES(512), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_wen(mem_wen), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            wen_cnt <= wen_cnt + 1;
        end
        mem_rdata <= mem[mem_addr[8:2]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    task automatic access(input int k, input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        req_we[k] = we;
        req_size[2*k +: 2] = sz;
        req_unsigned[k] = uns;
        req_addr[32*k +: 32] = a;
        req_wdata[32*k +: 32] = d;
        req_valid[k] = 1'b1;
        #1;
        while (!req_ready[k] && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        c_rdy = req_ready;
        @(posedge clk);
        #1 req_valid[k] = 1'b0;
        @(negedge clk);
        c_be = mem_be; c_wen = mem_wen; c_addr = mem_addr; c_wdata = mem_wdata;
        @(negedge clk);
        c_rv = resp_valid; c_err = resp_err; c_rdata = resp_rdata;
    endtask

    function automatic logic [1:0] onehot(input int k);
        return (k == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic st(input int k, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] m;
        access(k, 1'b1, sz, 1'b0, a, d);
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        chk("st_ready", 64'(c_rdy), 64'(onehot(k)));
        chk("st_be", 64'(c_be), 64'(be));
        chk("st_wen", 64'(c_wen), 64'd1);
        chk("st_addr", 64'(c_addr), 64'({a[31:2], 2'b00}));
        chk("st_wdata", 64'(c_wdata & m), 64'(wd & m));
        chk("st_resp", 64'({c_rv, c_err, c_rdata}), 64'({onehot(k), 1'b0, 32'h0}));
    endtask

    task automatic ld(input int k, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] exp);
        access(k, 1'b0, sz, uns, a, 32'h0);
        chk("ld_ready", 64'(c_rdy), 64'(onehot(k)));
        chk("ld_wen", 64'(c_wen), 64'd0);
        chk("ld_resp", 64'({c_rv, c_err}), 64'({onehot(k), 1'b0}));
        chk("ld_rdata", 64'(c_rdata), 64'(exp));
    endtask

    task automatic bad(input int k, input logic we, input logic [1:0] sz, input logic [31:0] a);
        access(k, we, sz, 1'b0, a, 32'hA5A5A5A5);
        chk("err_mem", 64'({c_be, c_wen}), 64'd0);
        chk("err_resp", 64'({c_rv, c_err, c_rdata}), 64'({onehot(k), 1'b1, 32'h0}));
    endtask

    task automatic chk_outs_zero(input string tag);
        chk(tag, 64'({req_ready, resp_valid, resp_err, mem_be, mem_wen}), 64'd0);
        chk({tag, "_data"}, {resp_rdata, mem_wdata}, 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    endtask

    initial begin
        int w0, ngr, nrs, gexp;
        logic [1:0] own [$];
        logic [1:0] o;
        req_valid = 2'b11; req_we = '0; req_size = '0; req_unsigned = '0;
        req_addr = '0; req_wdata = '0;

        // Reset: outputs quiet even with both requesters asserting
        repeat (2) @(negedge clk);
        chk_outs_zero("reset");
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        st(0, 2'b10, 32'h10, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        ld(0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        st(0, 2'b00, 32'h21, 32'h00000080, 4'b0100, 32'h00800000);
        ld(0, 2'b00, 1'b0, 32'h21, 32'hFFFFFF80);
        ld(0, 2'b00, 1'b1, 32'h21, 32'h00000080);
        st(0, 2'b01, 32'h22, 32'h0000BEEF, 4'b0011, 32'h0000BEEF);
        ld(1, 2'b01, 1'b0, 32'h22, 32'hFFFFBEEF);
        ld(1, 2'b01, 1'b1, 32'h22, 32'h0000BEEF);
        ld(1, 2'b10, 1'b0, 32'h20, 32'h0080BEEF);
        ld(0, 2'b00, 1'b0, 32'h20, 32'h00000000);
        // Top-of-memory boundary: last byte/half/word are legal
        st(1, 2'b00, 32'h1FF, 32'h0000005A, 4'b0001, 32'h0000005A);
        ld(1, 2'b10, 1'b1, 32'h1FC, 32'h0000005A);
        ld(0, 2'b01, 1'b0, 32'h1FE, 32'h0000005A);

        w0 = wen_cnt;
        bad(0, 1'b1, 2'b10, 32'h13);
        bad(0, 1'b1, 2'b01, 32'h05);
        bad(1, 1'b1, 2'b11, 32'h10);
        bad(0, 1'b1, 2'b00, 32'd512);
        bad(1, 1'b0, 2'b00, 32'hFFFFFFFF);
        bad(0, 1'b1, 2'b01, 32'h200);
        bad(1, 1'b1, 2'b10, 32'hFFFFFFFC);
        chk("err_no_write", 64'(wen_cnt - w0), 64'd0);
        ld(0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        ld(1, 2'b10, 1'b0, 32'h04, 32'h00000000);

        // Reset during ISSUE of a store: write dropped, pointer back to requester 0
        @(negedge clk);
        req_we[0] = 1'b1; req_size[1:0] = 2'b10; req_addr[31:0] = 32'h40;
        req_wdata[31:0] = 32'hCAFEF00D; req_valid[0] = 1'b1;
        #1 chk("rst_pre_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 chk("rst_pre_wen", 64'(mem_wen), 64'd1);
        req_we[1] = 1'b0; req_size[3:2] = 2'b10; req_unsigned[1] = 1'b0;
        req_addr[63:32] = 32'h20; req_valid[1] = 1'b1;
        rst_n = 1'b0;
        #1 chk_outs_zero("rst_async");
        req_we[0] = 1'b0;
        @(negedge clk);
        chk_outs_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters held valid: grants alternate starting at 0
        ngr = 0; nrs = 0; gexp = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            #1;
            if (req_ready != 2'b00) begin
                chk("arb_grant", 64'(req_ready), 64'(onehot(gexp)));
                own.push_back(onehot(gexp));
                gexp = 1 - gexp;
                ngr++;
            end
            if (resp_valid != 2'b00) begin
                o = (own.size() > 0) ? own.pop_front() : 2'b00;
                chk("arb_owner", 64'(resp_valid), 64'(o));
                chk("arb_rdata", 64'({resp_err, resp_rdata}),
                    64'({1'b0, (o == 2'b01) ? 32'h0 : 32'h0080BEEF}));
                nrs++;
            end
            @(negedge clk);
        end
        chk("arb_ngrant", 64'(ngr), 64'd5);
        chk("arb_nresp", 64'(nrs), 64'd4);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_store_dropped", 64'(mem[16]), 64'd0);

        // Requester 1 withdraws while requester 0 is being served
        req_we[0] = 1'b0; req_size[1:0] = 2'b10; req_addr[31:0] = 32'h10; req_valid[0] = 1'b1;
        #1 chk("wd_ready0", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 2'b10;
        @(negedge clk);
        chk("wd_issue_noready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(negedge clk);
        chk("wd_resp", 64'({req_ready, resp_valid, resp_rdata}), 64'({2'b00, 2'b01, 32'hDEADBEEF}));
        o = 2'b00;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            o = o | req_ready | resp_valid;
        end
        chk("wd_idle", 64'({o, mem_be, mem_wen}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Shares the single-port, byte-addressed data memory between two requesters: requester 0 is the CPU load/store unit, requester 1 is the debug/loader port.
- Round-robin arbitration, one access in flight at a time.
- Handles byte/half/word sizing, byte-lane write enables, load sign/zero extension, and rejects misaligned or out-of-range accesses.
- Sits between the requesters and the data memory. The memory has a registered read with 1-cycle latency.

Parameters:
- MEM_BYTES, 512, size of the memory in bytes; valid byte addresses are 0..MEM_BYTES-1.
- ADDR_WIDTH, 32, width of the request and memory addresses.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  2  per-requester request valid; bit k = requester k.
- req_ready  out  2  one-hot, 1-cycle acceptance pulse.
- req_we  in  2  1 = store, 0 = load.
- req_size  in  4  {r1,r0}, 2 bits each; 00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  2  load zero-extend (1) or sign-extend (0).
- req_addr  in  2*ADDR_WIDTH  {r1,r0} byte addresses.
- req_wdata  in  64  {r1,r0}; store data, right-justified.
- resp_valid  out  2  one-hot, 1-cycle response pulse to the owning requester.
- resp_rdata  out  32  load result; 0 for stores and for errors.
- resp_err  out  1  qualified by resp_valid; misaligned, out-of-range or illegal size.
- mem_addr  out  ADDR_WIDTH  word-aligned address, {addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-placed store data.
- mem_be  out  4  byte-lane enables, bit i = bits [8i+7:8i].
- mem_wen  out  1  write strobe.
- mem_rdata  in  32  memory read word, valid the cycle after the address is presented.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; round-robin pointer favours requester 0.
  - All outputs are 0: req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_be, mem_wen.
  - Any in-flight access is dropped with no response and no write.
- Lane map (big-endian within the word): the byte at offset o=addr[1:0] occupies bits [31-8o -: 8].
  - Half at offset o (o = 0 or 2) occupies bits [31-8o -: 16].
  - Word uses all 4 lanes.
- FSM: IDLE -> ISSUE -> RESP -> IDLE.
  - IDLE:
    - If any req_valid is set, grant one requester and pulse its req_ready for that cycle.
    - Latch that requester's we/size/unsigned/addr/wdata.
    - If both are valid, the pointer decides; after a grant to k the pointer moves to 1-k.
    - If only one is valid, it wins regardless of the pointer.
  - ISSUE:
    - Drive mem_addr.
    - For a legal store, set mem_be to the lane mask and mem_wen=1 for exactly this cycle.
    - mem_wdata = byte/half/word replicated into the target lanes.
    - For a legal load, set mem_be to the lane mask and mem_wen=0.
    - For an error, mem_be=0 and mem_wen=0; memory is untouched.
  - RESP:
    - Pulse resp_valid[grant].
    - For a load, extract the lanes from mem_rdata and sign- or zero-extend to 32 bits.
    - For a store or an error, resp_rdata=0.
    - resp_err is set as below. Return to IDLE.
- Error when any of these holds:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr + bytes > MEM_BYTES, compared unsigned without wrap (e.g. addr=0xFFFFFFFF byte → error).
- Latency and throughput:
  - Accept edge to resp_valid is 2 cycles.
  - Maximum throughput is 1 access per 3 cycles.
  - req_ready is never asserted outside IDLE.
- A requester must hold valid and its fields stable until req_ready. Deasserting before ready withdraws the request with no side effects.
- Outside ISSUE, mem_wen=0 and mem_be=0; mem_addr holds its last value.
- A requester may re-request in the same cycle it receives resp_valid. That request is seen when the FSM is back in IDLE, the next cycle.

Test Plan:
- Store then load, requester 0:
  - Store word 0xDEADBEEF at addr 0x10: mem_be=1111 and mem_wen for one cycle.
  - Load word from 0x10 → resp_rdata=0xDEADBEEF, resp_err=0, 2 cycles after accept.
- Byte lanes and extension:
  - Store byte 0x80 at 0x21: mem_be=0100, mem_wdata[23:16]=0x80.
  - Signed byte load from 0x21 → 0xFFFFFF80; unsigned → 0x00000080.
  - Half store 0xBEEF at 0x22 → mem_be=0011.
- Arbitration:
  - Both requesters valid continuously: grants alternate 0,1,0,1.
  - resp_valid goes to the matching requester each time; nothing is lost or duplicated.
- Errors:
  - Word at 0x13, half at 0x05, size=11, and byte at 512 (MEM_BYTES=512) → resp_err=1, rdata=0.
  - mem_wen never asserts for any of these; a subsequent load shows memory unchanged.
- Reset mid-operation:
  - Assert rst_n=0 asynchronously during ISSUE of a store.
  - All outputs go to 0 immediately, no resp_valid.
  - After release, the first grant goes to requester 0 when both are valid.
- Withdrawn request:
  - Requester 1 drops valid while FSM is in RESP serving requester 0 → no grant to 1, FSM idles.
